rx_block_lock_descrambler: RTL and testbench

// - Receive-side PCS stage between the 64b->66b rx gearbox and the rx MAC; inverse of the tx scrambler/header path.
// - Acquires 66b block lock from sync headers (802.3 cl.49 lock FSM) and drives gearbox slip until lock.
// - Self-synchronously descrambles the payload (x^58+x^39+1) and flags high BER.
// - Passes headers through aligned to the descrambled data.

---
 rtl/rx_block_lock_descrambler_pkg.sv | 33 +++
 rtl/rx_block_lock_descrambler_descrambler_58b.sv | 52 +++++
 rtl/rx_block_lock_descrambler.sv | 198 +++++++++++++++++++
 tb/tb_rx_block_lock_descrambler.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_block_lock_descrambler_pkg.sv
// ----------------------------------------------------------------------------
// rx_block_lock_descrambler_pkg
// Shared definitions for the receive-side 64b/66b block-lock and descrambler
// stage: sync header codes, scrambler polynomial taps, datapath widths and
// the block-lock state encoding.
// Ports: none (package).
// ----------------------------------------------------------------------------
package rx_block_lock_descrambler_pkg;

    // Sync header codes carried in front of each 66b block.
    localparam logic [1:0] SH_DATA = 2'b01;
    localparam logic [1:0] SH_CTRL = 2'b10;

    // Scrambler polynomial x^58 + x^39 + 1: taps into the 58-bit history.
    localparam int SCR_W  = 58;
    localparam int TAP_A  = 38;
    localparam int TAP_B  = 57;
    localparam int DATA_W = 32;

    // Block-lock state machine states.
    typedef enum logic [1:0] {
        LOCK_INIT = 2'd0,
        RESET_CNT = 2'd1,
        TEST_SH   = 2'd2,
        SLIP      = 2'd3
    } lock_state_e;

    // A header is legal only if its two bits differ.
    function automatic logic sh_is_valid(input logic [1:0] head);
        return (head == SH_DATA) || (head == SH_CTRL);
    endfunction

endpackage

// File: rtl/rx_block_lock_descrambler_descrambler_58b.sv
// ----------------------------------------------------------------------------
// descrambler_58b
// 32-bit parallel self-synchronising descrambler for x^58 + x^39 + 1.
// Bit k of each word (LSB first) is descrambled with the history of received
// scrambled bits, and those received bits then enter the history, so the
// state converges to the transmitter's after 58 received bits.
// Ports:
//   clk_i   in   1   clock
//   rst_i   in   1   synchronous active-high reset
//   en_i    in   1   advance state and update data_o this cycle
//   data_i  in   32  scrambled word
//   data_o  out  32  descrambled word, registered (1 cycle latency)
// ----------------------------------------------------------------------------
module descrambler_58b
    import rx_block_lock_descrambler_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o
);

    logic [SCR_W-1:0]  scr_state_q;
    logic [SCR_W-1:0]  scr_state_d;
    logic [DATA_W-1:0] descr_word;

    // Unroll the serial descrambler over the 32 bits of the word. Bit 0 is
    // the oldest bit on the wire, so it is processed first and the history
    // shifts by one after every bit.
    always_comb begin
        scr_state_d = scr_state_q;
        descr_word  = '0;
        for (int k = 0; k < DATA_W; k++) begin
            descr_word[k] = data_i[k] ^ scr_state_d[TAP_A] ^ scr_state_d[TAP_B];
            scr_state_d   = {scr_state_d[SCR_W-2:0], data_i[k]};
        end
    end

    // History and output only move on valid words; gearbox pause cycles
    // leave both untouched.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scr_state_q <= '0;
            data_o      <= '0;
        end else if (en_i) begin
            scr_state_q <= scr_state_d;
            data_o      <= descr_word;
        end
    end

endmodule

// File: rtl/rx_block_lock_descrambler.sv
// ----------------------------------------------------------------------------
// rx_block_lock_descrambler
// Receive PCS stage between the 64b->66b gearbox and the MAC. Acquires 66b
// block lock from sync headers, requests gearbox bit slips until lock,
// descrambles the payload and raises a high bit-error-rate flag.
// Ports:
//   clk_i          in   1   rx user clock
//   rst_i          in   1   synchronous active-high reset
//   data_i         in   32  scrambled payload word from gearbox
//   data_valid_i   in   1   data_i valid (low in gearbox pause cycles)
//   head_i         in   2   sync header of current block
//   head_valid_i   in   1   head_i valid, one pulse per block on first word
//   slip_o         out  1   one-cycle pulse: gearbox shifts by one bit
//   data_o         out  32  descrambled payload (1 cycle latency)
//   data_valid_o   out  1   data_o valid
//   head_o         out  2   header aligned to data_o
//   head_valid_o   out  1   head_o valid, aligned to data_o
//   block_lock_o   out  1   block lock achieved
//   hi_ber_o       out  1   high bit-error-rate indication
// ----------------------------------------------------------------------------
module rx_block_lock_descrambler
    import rx_block_lock_descrambler_pkg::*;
#(
    parameter int P_LOCK_CNT    = 64,
    parameter int P_INVALID_MAX = 16,
    parameter int P_SLIP_WAIT   = 32,
    parameter int P_BER_WINDOW  = 3125,
    parameter int P_BER_MAX     = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              data_valid_i,
    input  logic [1:0]        head_i,
    input  logic              head_valid_i,
    output logic              slip_o,
    output logic [DATA_W-1:0] data_o,
    output logic              data_valid_o,
    output logic [1:0]        head_o,
    output logic              head_valid_o,
    output logic              block_lock_o,
    output logic              hi_ber_o
);

    localparam int SH_W = $clog2(P_LOCK_CNT + 1);
    localparam int IV_W = $clog2(P_INVALID_MAX + 1);
    localparam int SW_W = $clog2(P_SLIP_WAIT);
    localparam int BW_W = $clog2(P_BER_WINDOW);
    localparam int BI_W = $clog2(P_BER_MAX + 1);

    lock_state_e     state_q, state_d;
    logic [SH_W-1:0] sh_cnt_q, sh_cnt_d;
    logic [IV_W-1:0] inv_cnt_q, inv_cnt_d;
    logic [SW_W-1:0] wait_cnt_q, wait_cnt_d;
    logic            lock_d;
    logic            hdr_ok;
    logic [BW_W-1:0] ber_win_q;
    logic [BI_W-1:0] ber_inv_q;
    logic [BI_W-1:0] ber_inv_inc;

    assign hdr_ok = sh_is_valid(head_i);

    // Payload descrambler runs on every valid word, locked or not, so it is
    // already synchronised by the time lock is declared.
    descrambler_58b u_descrambler (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .en_i   (data_valid_i),
        .data_i (data_i),
        .data_o (data_o)
    );

    // Header and valid flags are delayed one cycle so they line up with the
    // registered descrambler output.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_valid_o <= 1'b0;
            head_o       <= 2'b00;
            head_valid_o <= 1'b0;
        end else begin
            data_valid_o <= data_valid_i;
            head_o       <= head_i;
            head_valid_o <= head_valid_i;
        end
    end

    // Lock FSM state register together with its window counters and the
    // lock flag, all computed by the next-state process below.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= LOCK_INIT;
            sh_cnt_q     <= '0;
            inv_cnt_q    <= '0;
            wait_cnt_q   <= '0;
            block_lock_o <= 1'b0;
        end else begin
            state_q      <= state_d;
            sh_cnt_q     <= sh_cnt_d;
            inv_cnt_q    <= inv_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            block_lock_o <= lock_d;
        end
    end

    // Next-state logic. RESET_CNT tests a header arriving in its own cycle as
    // the first of the new window, so no header is lost between windows.
    // While locked, the invalid-limit check comes before the window-end
    // check so a limit reached on the last header of a window still slips.
    always_comb begin
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        inv_cnt_d  = inv_cnt_q;
        wait_cnt_d = '0;
        lock_d     = block_lock_o;
        case (state_q)
            LOCK_INIT: begin
                lock_d  = 1'b0;
                state_d = RESET_CNT;
            end
            RESET_CNT, TEST_SH: begin
                state_d = TEST_SH;
                if (state_q == RESET_CNT) begin
                    sh_cnt_d  = '0;
                    inv_cnt_d = '0;
                end
                if (head_valid_i) begin
                    sh_cnt_d = sh_cnt_d + SH_W'(1);
                    if (!hdr_ok) begin
                        inv_cnt_d = inv_cnt_d + IV_W'(1);
                    end
                    if (!block_lock_o) begin
                        if (!hdr_ok) begin
                            state_d = SLIP;
                        end else if (sh_cnt_d == SH_W'(P_LOCK_CNT)) begin
                            lock_d  = 1'b1;
                            state_d = RESET_CNT;
                        end
                    end else begin
                        if (!hdr_ok && (inv_cnt_d == IV_W'(P_INVALID_MAX))) begin
                            lock_d  = 1'b0;
                            state_d = SLIP;
                        end else if (sh_cnt_d == SH_W'(P_LOCK_CNT)) begin
                            state_d = RESET_CNT;
                        end
                    end
                end
            end
            SLIP: begin
                if (wait_cnt_q == SW_W'(P_SLIP_WAIT - 1)) begin
                    state_d = RESET_CNT;
                end else begin
                    wait_cnt_d = wait_cnt_q + SW_W'(1);
                end
            end
            default: begin
                state_d = LOCK_INIT;
            end
        endcase
    end

    // Slip request is the first cycle spent in SLIP; the rest of the stay is
    // the gearbox settle time.
    always_comb begin
        slip_o = (state_q == SLIP) && (wait_cnt_q == '0);
    end

    // Saturating increment of the BER invalid-header count.
    always_comb begin
        ber_inv_inc = ber_inv_q;
        if (!hdr_ok && (ber_inv_q != BI_W'(P_BER_MAX))) begin
            ber_inv_inc = ber_inv_q + BI_W'(1);
        end
    end

    // BER monitor: only meaningful while locked. A header that costs lock
    // clears the measurement rather than closing the window.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ber_win_q <= '0;
            ber_inv_q <= '0;
            hi_ber_o  <= 1'b0;
        end else if (!block_lock_o || !lock_d) begin
            ber_win_q <= '0;
            ber_inv_q <= '0;
            hi_ber_o  <= 1'b0;
        end else if (head_valid_i) begin
            if (ber_win_q == BW_W'(P_BER_WINDOW - 1)) begin
                hi_ber_o  <= (ber_inv_inc >= BI_W'(P_BER_MAX));
                ber_win_q <= '0;
                ber_inv_q <= '0;
            end else begin
                ber_win_q <= ber_win_q + BW_W'(1);
                ber_inv_q <= ber_inv_inc;
            end
        end
    end

endmodule

// File: tb/tb_rx_block_lock_descrambler.sv
// ----------------------------------------------------------------------------
// tb_rx_block_lock_descrambler
// Drives 66b block streams (header pulse on the first of two words) into the
// block-lock/descrambler stage with random payload scrambled by a transmit
// scrambler model, and compares every output cycle against a header-level
// lock/BER reference model.
// ----------------------------------------------------------------------------
module tb_rx_block_lock_descrambler;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] data_i = '0;
    logic        data_valid_i = 1'b0;
    logic [1:0]  head_i = 2'b00;
    logic        head_valid_i = 1'b0;
    logic        slip_o;
    logic [31:0] data_o;
    logic        data_valid_o;
    logic [1:0]  head_o;
    logic        head_valid_o;
    logic        block_lock_o;
    logic        hi_ber_o;

    int n_cmp  = 0;
    int n_fail = 0;
    int slip_seen = 0;

    // Reference model state: transmitted scrambled bit history (oldest
    // first) and the per-header lock / BER bookkeeping.
    int tx_hist[$];
    bit m_locked;
    int m_win;
    int m_inv;
    int m_ignore;
    bit m_slip_now;
    int m_bwin;
    int m_binv;
    bit m_hiber;

    always #5 clk_i = ~clk_i;

    rx_block_lock_descrambler dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data_i       (data_i),
        .data_valid_i (data_valid_i),
        .head_i       (head_i),
        .head_valid_i (head_valid_i),
        .slip_o       (slip_o),
        .data_o       (data_o),
        .data_valid_o (data_valid_o),
        .head_o       (head_o),
        .head_valid_o (head_valid_o),
        .block_lock_o (block_lock_o),
        .hi_ber_o     (hi_ber_o)
    );

    // Reset the model to the post-reset condition of the link.
    task automatic model_reset();
        tx_hist.delete();
        for (int i = 0; i < 58; i++) tx_hist.push_back(0);
        m_locked   = 1'b0;
        m_win      = 0;
        m_inv      = 0;
        m_ignore   = 0;
        m_slip_now = 1'b0;
        m_bwin     = 0;
        m_binv     = 0;
        m_hiber    = 1'b0;
    endtask

    // Transmit scrambler: each plaintext bit is mixed with the scrambled
    // bits sent 39 and 58 bit-times earlier.
    task automatic scramble_word(input logic [31:0] plain, output logic [31:0] scr);
        int b;
        scr = '0;
        for (int k = 0; k < 32; k++) begin
            b = int'(plain[k]) ^ tx_hist[tx_hist.size() - 39] ^ tx_hist[tx_hist.size() - 58];
            scr[k] = b[0];
            tx_hist.push_back(b);
            void'(tx_hist.pop_front());
        end
    endtask

    task automatic start_slip();
        m_win      = 0;
        m_inv      = 0;
        m_ignore   = 32;
        m_slip_now = 1'b1;
    endtask

    // Header-level lock and BER rules.
    task automatic model_header(input logic [1:0] h);
        bit ok;
        ok = (h == 2'b01) || (h == 2'b10);
        if (m_locked) begin
            m_bwin++;
            if (!ok && m_binv < 16) m_binv++;
            if (m_bwin == 3125) begin
                m_hiber = (m_binv >= 16);
                m_bwin  = 0;
                m_binv  = 0;
            end
        end
        m_win++;
        if (!ok) m_inv++;
        if (!m_locked) begin
            if (!ok) start_slip();
            else if (m_win == 64) begin
                m_locked = 1'b1;
                m_win    = 0;
                m_inv    = 0;
            end
        end else begin
            if (!ok && m_inv == 16) begin
                m_locked = 1'b0;
                start_slip();
                m_bwin  = 0;
                m_binv  = 0;
                m_hiber = 1'b0;
            end else if (m_win == 64) begin
                m_win = 0;
                m_inv = 0;
            end
        end
    endtask

    // Drive one clock cycle and score every output against the model.
    task automatic drive_cycle(input bit dv, input bit hv, input logic [1:0] h,
                               input logic [31:0] plain);
        logic [31:0] scr;
        if (dv) scramble_word(plain, scr);
        else scr = $urandom;
        m_slip_now = 1'b0;
        if (m_ignore > 0) m_ignore--;
        else if (hv) model_header(h);
        data_i       = scr;
        data_valid_i = dv;
        head_i       = h;
        head_valid_i = hv;
        @(posedge clk_i);
        #1;
        if (slip_o) slip_seen++;
        n_cmp++;
        if (data_valid_o !== dv || head_valid_o !== hv) begin
            n_fail++;
            $display("[TB] FAIL valid_flags t=%0t got dv=%b hv=%b want dv=%b hv=%b",
                     $time, data_valid_o, head_valid_o, dv, hv);
        end
        if (hv) begin
            n_cmp++;
            if (head_o !== h) begin
                n_fail++;
                $display("[TB] FAIL head_o t=%0t got %b want %b", $time, head_o, h);
            end
        end
        if (dv) begin
            n_cmp++;
            if (data_o !== plain) begin
                n_fail++;
                $display("[TB] FAIL data_o t=%0t got %h want %h", $time, data_o, plain);
            end
        end
        n_cmp++;
        if (slip_o !== m_slip_now || block_lock_o !== m_locked || hi_ber_o !== m_hiber) begin
            n_fail++;
            $display("[TB] FAIL lock_state t=%0t got slip=%b lock=%b hiber=%b want slip=%b lock=%b hiber=%b",
                     $time, slip_o, block_lock_o, hi_ber_o, m_slip_now, m_locked, m_hiber);
        end
    endtask

    function automatic logic [1:0] good_hdr();
        return ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [1:0] bad_hdr();
        return ($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11;
    endfunction

    task automatic send_block(input logic [1:0] h);
        drive_cycle(1'b1, 1'b1, h, $urandom);
        drive_cycle(1'b1, 1'b0, 2'b00, $urandom);
    endtask

    // Hold reset for three cycles, check every output is cleared, release
    // and idle while the FSM walks out of its initial states.
    task automatic apply_reset();
        rst_i        = 1'b1;
        data_valid_i = 1'b0;
        head_valid_i = 1'b0;
        data_i       = $urandom;
        head_i       = 2'b11;
        repeat (3) @(posedge clk_i);
        #1;
        n_cmp++;
        if ({slip_o, data_o, data_valid_o, head_o, head_valid_o, block_lock_o, hi_ber_o} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs got slip=%b data=%h dv=%b head=%b hv=%b lock=%b hiber=%b want all 0",
                     slip_o, data_o, data_valid_o, head_o, head_valid_o, block_lock_o, hi_ber_o);
        end
        rst_i = 1'b0;
        model_reset();
        repeat (3) drive_cycle(1'b0, 1'b0, 2'b00, 32'h0);
        slip_seen = 0;
    endtask

    task automatic test_reset();
        $display("[TB] test_reset");
        apply_reset();
    endtask

    task automatic test_clean_lock();
        $display("[TB] test_clean_lock");
        repeat (63) send_block(good_hdr());
        n_cmp++;
        if (block_lock_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL lock_after_63 got %b want 0", block_lock_o);
        end
        send_block(good_hdr());
        n_cmp++;
        if (block_lock_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL lock_after_64 got %b want 1", block_lock_o);
        end
        repeat (10) send_block(good_hdr());
        n_cmp++;
        if (slip_seen != 0) begin
            n_fail++;
            $display("[TB] FAIL clean_no_slip got %0d slips want 0", slip_seen);
        end
    endtask

    task automatic test_locked_invalid();
        bit bad[64];
        int nbad;
        int idx;
        $display("[TB] test_locked_invalid");
        while (m_win != 0) send_block(good_hdr());
        // Window with 15 invalid headers at random positions.
        for (int i = 0; i < 64; i++) bad[i] = 1'b0;
        nbad = 0;
        while (nbad < 15) begin
            idx = $urandom_range(0, 63);
            if (!bad[idx]) begin
                bad[idx] = 1'b1;
                nbad++;
            end
        end
        for (int i = 0; i < 64; i++) send_block(bad[i] ? bad_hdr() : good_hdr());
        n_cmp++;
        if (block_lock_o !== 1'b1 || slip_seen != 0) begin
            n_fail++;
            $display("[TB] FAIL lock_15_invalid got lock=%b slips=%0d want lock=1 slips=0",
                     block_lock_o, slip_seen);
        end
        // Window with 16 invalid headers; stop at the 16th.
        for (int i = 0; i < 64; i++) bad[i] = 1'b0;
        nbad = 0;
        while (nbad < 16) begin
            idx = $urandom_range(0, 63);
            if (!bad[idx]) begin
                bad[idx] = 1'b1;
                nbad++;
            end
        end
        nbad = 0;
        for (int i = 0; i < 64 && nbad < 16; i++) begin
            if (bad[i]) nbad++;
            send_block(bad[i] ? bad_hdr() : good_hdr());
        end
        repeat (20) send_block(good_hdr());
        n_cmp++;
        if (block_lock_o !== 1'b0 || slip_seen != 1) begin
            n_fail++;
            $display("[TB] FAIL lock_16_invalid got lock=%b slips=%0d want lock=0 slips=1",
                     block_lock_o, slip_seen);
        end
    endtask

    task automatic test_slip_before_lock();
        $display("[TB] test_slip_before_lock");
        apply_reset();
        repeat (9) send_block(good_hdr());
        send_block(2'b11);
        n_cmp++;
        if (slip_seen != 1) begin
            n_fail++;
            $display("[TB] FAIL slip_pulse got %0d slips want 1", slip_seen);
        end
        repeat (16) send_block(good_hdr());
        repeat (63) send_block(good_hdr());
        n_cmp++;
        if (block_lock_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL relock_early got %b want 0", block_lock_o);
        end
        send_block(good_hdr());
        n_cmp++;
        if (block_lock_o !== 1'b1 || slip_seen != 1) begin
            n_fail++;
            $display("[TB] FAIL relock got lock=%b slips=%0d want lock=1 slips=1",
                     block_lock_o, slip_seen);
        end
    endtask

    task automatic test_pause();
        bit first;
        int npause;
        $display("[TB] test_pause");
        first  = 1'b1;
        npause = 0;
        for (int c = 0; c < 400; c++) begin
            if (c % 33 == 32) begin
                drive_cycle(1'b0, 1'b0, 2'b00, 32'h0);
                npause++;
                n_cmp++;
                if (data_valid_o !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL pause_dv got %b want 0", data_valid_o);
                end
            end else begin
                drive_cycle(1'b1, first, first ? good_hdr() : 2'b00, $urandom);
                first = ~first;
            end
        end
        n_cmp++;
        if (block_lock_o !== 1'b1 || npause != 12) begin
            n_fail++;
            $display("[TB] FAIL pause_lock got lock=%b pauses=%0d want lock=1 pauses=12",
                     block_lock_o, npause);
        end
    endtask

    task automatic test_ber();
        int off;
        $display("[TB] test_ber");
        apply_reset();
        repeat (64) send_block(good_hdr());
        off = $urandom_range(0, 63);
        for (int i = 0; i < 3125; i++) begin
            send_block((i < 1024 && (i % 64) == off) ? bad_hdr() : good_hdr());
            if (i == 3123) begin
                n_cmp++;
                if (hi_ber_o !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL hiber_before_end got %b want 0", hi_ber_o);
                end
            end
        end
        n_cmp++;
        if (hi_ber_o !== 1'b1 || block_lock_o !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL hiber_set got hiber=%b lock=%b want hiber=1 lock=1",
                     hi_ber_o, block_lock_o);
        end
        for (int i = 0; i < 3125; i++) begin
            send_block(good_hdr());
            if (i == 3123) begin
                n_cmp++;
                if (hi_ber_o !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL hiber_held got %b want 1", hi_ber_o);
                end
            end
        end
        n_cmp++;
        if (hi_ber_o !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL hiber_clear got %b want 0", hi_ber_o);
        end
    endtask

    task automatic test_reset_mid();
        $display("[TB] test_reset_mid");
        drive_cycle(1'b1, 1'b1, good_hdr(), $urandom);
        apply_reset();
        repeat (64) send_block(good_hdr());
        n_cmp++;
        if (block_lock_o !== 1'b1 || slip_seen != 0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_relock got lock=%b slips=%0d want lock=1 slips=0",
                     block_lock_o, slip_seen);
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_clean_lock();
        test_locked_invalid();
        test_slip_before_lock();
        test_pause();
        test_ber();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
